// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 16x-oversampled UART receiver with mid-bit sampling, receive FIFO and sticky error flags.
// Define UART_RX_PARITY_EN to add a parity bit (8 data + parity + 1 stop); otherwise the frame is 8N1.
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          parity_odd,
    input  logic                          rx,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          parity_err,
    input  logic                          err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_START      = 3'd1;
    localparam logic [2:0] S_DATA       = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY     = 3'd3;
`endif
    localparam logic [2:0] S_STOP       = 3'd4;
    localparam logic [2:0] S_BREAK_WAIT = 3'd5;

    logic             rx_meta_q, rx_s_q, rx_prev_q;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]       os_cnt_q, os_cnt_d;
    logic [2:0]       state_q, state_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [7:0]       mem [FIFO_DEPTH];

    logic tick, start_edge, push, frame_set, pop, push_ok, full;

`ifdef UART_RX_PARITY_EN
    logic parity_err_q, parity_err_d, par_bad_q, par_bad_d, par_set;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    assign tick       = (div_cnt_q >= baud_div);
    assign start_edge = (state_q == S_IDLE) && enable && rx_prev_q && !rx_s_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        par_set   = 1'b0;
`endif
        div_cnt_d = (start_edge || tick) ? '0 : div_cnt_q + DIV_W'(1);

        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        state_d  = S_START;
                        os_cnt_d = '0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (os_cnt_q == 4'd7) begin
                            os_cnt_d  = '0;
                            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                            par_bad_d = 1'b0;
`endif
                            state_d   = rx_s_q ? S_IDLE : S_DATA;
                        end else begin
                            os_cnt_d = os_cnt_q + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        os_cnt_d = os_cnt_q + 4'd1;
                        if (os_cnt_q == 4'd15) begin
                            shift_d   = {rx_s_q, shift_q[7:1]};
                            bit_idx_d = bit_idx_q + 3'd1;
                            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state_d = S_PARITY;
`else
                                state_d = S_STOP;
`endif
                            end
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        os_cnt_d = os_cnt_q + 4'd1;
                        if (os_cnt_q == 4'd15) begin
                            par_bad_d = ((^shift_q) ^ rx_s_q) != parity_odd;
                            par_set   = par_bad_d;
                            state_d   = S_STOP;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        os_cnt_d = os_cnt_q + 4'd1;
                        if (os_cnt_q == 4'd15) begin
                            if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
                                push = !par_bad_q;
`else
                                push = 1'b1;
`endif
                                state_d = S_IDLE;
                            end else begin
                                frame_set = 1'b1;
                                state_d   = S_BREAK_WAIT;
                            end
                        end
                    end
                end
                // A line held low after a bad stop bit must go high before a new start can be seen.
                S_BREAK_WAIT: if (rx_s_q) state_d = S_IDLE;
                default:      state_d = S_IDLE;
            endcase
        end
    end

    // FIFO bookkeeping: a pop in the same cycle frees the entry a full-FIFO push needs.
    always_comb begin
        pop      = (count_q != '0) && m_ready;
        full     = (count_q == DEPTH_CNT);
        push_ok  = push && (!full || pop);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop)      count_d = count_q + ONE_CNT;
        else if (!push_ok && pop) count_d = count_q - ONE_CNT;
        overrun_d   = (push && full && !pop) ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
        frame_err_d = frame_set ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
`ifdef UART_RX_PARITY_EN
        parity_err_d = par_set ? 1'b1 : (err_clr ? 1'b0 : parity_err_q);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            os_cnt_q    <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
            par_bad_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            rx_prev_q   <= rx_s_q;
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            os_cnt_q    <= os_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
            par_bad_q    <= par_bad_d;
`endif
        end
    end

    // NOTE: storage is not reset; emptiness is tracked by count_q and m_data is gated while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= shift_q;
    end

    assign m_valid    = (count_q != '0);
    assign m_data     = m_valid ? mem[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: stimulus pushes expected bytes, a monitor pops and compares on every handshake.
module tb_uart_rx_ctrl;

    localparam int FIFO_DEPTH = 4;
    localparam int DIV_W      = 16;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        enable;
    logic [DIV_W-1:0]            baud_div;
    logic                        parity_odd;
    logic                        rx;
    logic [7:0]                  m_data;
    logic                        m_valid;
    logic                        m_ready;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        busy;
    logic                        frame_err;
    logic                        overrun;
    logic                        parity_err;
    logic                        err_clr;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    uart_rx_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .baud_div(baud_div),
        .parity_odd(parity_odd), .rx(rx), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .fifo_count(fifo_count), .busy(busy),
        .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted byte must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset && m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got=%02h expected=none", m_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    failures++;
                    $display("FAIL sb_data: got=%02h expected=%02h", m_data, e);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (16 * (int'(baud_div) + 1)) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^data) ^ parity_odd);
`endif
        send_bit(stop_bit);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; baud_div = '0; parity_odd = 1'b0;
        rx = 1'b1; m_ready = 1'b1; err_clr = 1'b0;
        idle(3);
        check("rst_m_valid", m_valid, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {frame_err, overrun, parity_err}, 0);
        check("rst_m_data", m_data, 8'h00);
        reset = 1'b1;
        idle(4);

        // 1: clean frames at 16 clk/bit, including all-zero and all-one payloads
        exp_q.push_back(8'hA5); send_frame(8'hA5, 1'b1); idle(20);
        check("t1_busy_idle", busy, 0);
        check("t1_flags", {frame_err, overrun, parity_err}, 0);
        exp_q.push_back(8'h00); send_frame(8'h00, 1'b1); idle(20);
        exp_q.push_back(8'hFF); send_frame(8'hFF, 1'b1); idle(20);
        check("t1_sb_drained", exp_q.size(), 0);
        check("t1_fifo_count", fifo_count, 0);

        // divider: tick every third clock, 48 clk/bit
        baud_div = 16'd2;
        exp_q.push_back(8'h81); send_frame(8'h81, 1'b1); idle(60);
        check("div_sb_drained", exp_q.size(), 0);
        check("div_flags", {frame_err, overrun, parity_err}, 0);
        baud_div = '0;
        idle(4);

        // 2: short glitch is a false start
        rx = 1'b0; idle(4);
        check("t2_busy_in_start", busy, 1);
        rx = 1'b1; idle(12);
        check("t2_busy_idle", busy, 0);
        check("t2_fifo_count", fifo_count, 0);
        check("t2_flags", {frame_err, overrun, parity_err}, 0);

        // 3: bad stop bit, line held low
        send_frame(8'h55, 1'b0);
        idle(40);
        check("t3_frame_err", frame_err, 1);
        check("t3_fifo_count", fifo_count, 0);
        check("t3_break_wait", busy, 1);
        rx = 1'b1; idle(10);
        check("t3_busy_idle", busy, 0);
        check("t3_frame_err_sticky", frame_err, 1);
        pulse_clr();
        check("t3_frame_err_clr", frame_err, 0);

        // 4: overflow with consumer stalled
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= FIFO_DEPTH) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
            idle(16);
        end
        check("t4_fifo_full", fifo_count, 4);
        check("t4_overrun", overrun, 1);
        check("t4_m_valid", m_valid, 1);
        check("t4_head", m_data, 8'h01);
        idle(5);
        check("t4_head_stable", m_data, 8'h01);
        m_ready = 1'b1; idle(8);
        check("t4_drained", fifo_count, 0);
        check("t4_sb_drained", exp_q.size(), 0);
        pulse_clr();
        check("t4_overrun_clr", overrun, 0);

        // 5: async reset mid-frame with a byte already buffered
        m_ready = 1'b0;
        send_frame(8'h99, 1'b1); idle(16);
        check("t5_prefill", fifo_count, 1);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        rx = 1'b1; idle(8);
        check("t5_busy_mid", busy, 1);
        reset = 1'b0;
        #1;
        check("t5_rst_m_valid", m_valid, 0);
        check("t5_rst_count", fifo_count, 0);
        idle(3);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_m_data", m_data, 8'h00);
        check("t5_rst_flags", {frame_err, overrun, parity_err}, 0);
        reset = 1'b1; m_ready = 1'b1; idle(4);
        exp_q.push_back(8'h3C); send_frame(8'h3C, 1'b1); idle(20);
        check("t5_sb_drained", exp_q.size(), 0);
        check("t5_flags", {frame_err, overrun, parity_err}, 0);

`ifdef UART_RX_PARITY_EN
        // 6: even parity, 0x07 needs parity bit 1; send it with 0 first
        parity_odd = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'(8'h07 >> i));
        send_bit(1'b0);
        send_bit(1'b1);
        idle(20);
        check("t6_parity_err", parity_err, 1);
        check("t6_no_push", fifo_count, 0);
        exp_q.push_back(8'h07); send_frame(8'h07, 1'b1); idle(20);
        check("t6_sb_drained", exp_q.size(), 0);
        pulse_clr();
        check("t6_parity_clr", parity_err, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller for the serial port. It divides the system clock into a 16x oversample tick and runs the start/data/stop sequencing with mid-bit sampling. Each received byte is buffered in a small FIFO, presented on a valid/ready stream to the bus/host side, and framing and overrun problems are reported as sticky error flags.

Parameters:
FIFO_DEPTH, 4, receive FIFO entries; power of 2, minimum 2
DIV_W, 16, width of baud_div

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset)
enable  input  1  receiver enable; low forces IDLE and keeps FIFO contents
baud_div  input  DIV_W  clocks per oversample tick minus 1; sampled continuously
parity_odd  input  1  1 = odd parity, 0 = even; used only with UART_RX_PARITY_EN
rx  input  1  asynchronous serial line, idle high
m_data  output  8  byte at FIFO head
m_valid  output  1  FIFO not empty
m_ready  input  1  consumer accepts m_data
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
busy  output  1  state != IDLE
frame_err  output  1  sticky: stop bit sampled 0
overrun  output  1  sticky: byte dropped because FIFO was full
parity_err  output  1  sticky: parity mismatch; always 0 without macro
err_clr  input  1  one-cycle pulse that clears all sticky flags

Behaviour:
- Reset values:
  - m_valid=0, fifo_count=0, busy=0, all error flags=0, m_data=0.
  - rx synchronizer=1, state=IDLE.
- rx synchronization: 2-flop synchronizer; rx_s is the output. All rx latency references below are to rx_s.
- Tick counter:
  - Counts 0..baud_div and pulses tick when it equals baud_div, then wraps to 0.
  - baud_div=0 gives a tick every clock.
  - Counter and oversample count os_cnt (0..15) both clear on start-edge detection.
- States: IDLE, START, DATA, [PARITY], STOP, BREAK_WAIT.
- IDLE: when enable=1 and rx_s falls from 1 to 0, go to START.
- START: on the tick where os_cnt=7 (mid start bit):
  - rx_s=0: go to DATA with os_cnt=0 and bit index=0.
  - rx_s=1: false start; return to IDLE with no flag.
- DATA:
  - Sample rx_s on every 16th tick after the previous sample; bits are LSB first into the shift register.
  - After bit 7, go to PARITY if the macro is defined, otherwise STOP.
- STOP: sample 16 ticks after the last bit.
  - rx_s=1: push the byte and go to IDLE.
  - rx_s=0: set frame_err, drop the byte, go to BREAK_WAIT.
- BREAK_WAIT: stay until rx_s=1, then go to IDLE. This prevents a held-low line from retriggering.
- enable=0 in any state: state goes to IDLE on the next clock; a partial frame is discarded silently.
- FIFO:
  - Push and pop in the same cycle are both honoured, including when full: the pop frees the entry.
  - Push when full with no pop: byte dropped and overrun set.
  - Pop happens when m_valid & m_ready.
  - m_data is stable while m_valid=1 and m_ready=0.
  - Latency: m_valid rises 1 clock after the stop-bit sample tick.
- Sticky flags: if a set event and err_clr occur in the same cycle, set wins.
- Reset asserted mid-frame: asynchronous return to reset values; FIFO is emptied.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - PARITY state samples one extra bit 16 ticks after bit 7.
  - Mismatch against parity_odd sets parity_err and drops the byte; the STOP check still runs.
  - Frame is 8 data + 1 parity + 1 stop.
- Undefined: no PARITY state, parity_odd is ignored, parity_err is tied to 0, frame is 8N1.

Test Plan:
1. baud_div=0 (16 clk/bit), send 8N1 frame 0xA5, m_ready=1 -> one m_valid pulse with m_data=0xA5; no error flags; busy back to 0 after the stop bit.
2. rx low for 4 clocks, then high -> no push, busy returns 0 within ~10 clocks, all flags 0.
3. Frame 0x55 with stop bit=0, rx held low 40 clocks then high -> frame_err=1, fifo_count=0, state stays BREAK_WAIT until rx high; err_clr pulse -> frame_err=0.
4. FIFO_DEPTH=4, m_ready=0, send 0x01..0x05 -> fifo_count=4, overrun=1; draining with m_ready=1 yields 0x01,0x02,0x03,0x04.
5. reset low during DATA bit 3, released, then frame 0x3C sent -> outputs at reset values during reset; afterwards m_data=0x3C with no errors.
6. Macro defined, parity_odd=0, frame 0x07 with parity bit 0 -> parity_err=1, no push; same frame with parity bit 1 -> m_data=0x07.
